// File: rtl/instr_mem_loader.sv
// Assembles MSB-first UART bytes into 32-bit instruction words and writes them
// to instruction memory from address 0 until a HALT word. `LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module instr_mem_loader #(
    parameter int             DATA_WIDTH  = 32,
    parameter int             DATA_DEPTH  = 128,
    parameter int             ADDR_WIDTH  = 7,
    parameter logic [5:0]     HALT_OPCODE = 6'b111111
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECV   = 3'd1,
        WRITE  = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4,
        CHKSUM = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [DATA_WIDTH-1:0]   wrData_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   wrAddr_q;
    logic [ADDR_WIDTH:0]     wordCount_q;
    logic [1:0]              byteIdx_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              chk_q;
`endif

    logic startSession;
    logic byteAccept;
    logic isHalt;
    logic lastByte;

    // Restart is only honoured when no session is actively receiving.
    assign startSession = i_start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign byteAccept   = (state_q == RECV) && i_rx_valid;
    assign lastByte     = byteIdx_q == 2'd3;
    assign isHalt       = wrData_q[DATA_WIDTH-1:DATA_WIDTH-6] == HALT_OPCODE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = RECV;
            RECV:    if (i_rx_valid && lastByte) state_d = WRITE;
            WRITE: begin
                if (isHalt) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHKSUM;
`else
                    state_d = DONE;
`endif
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ERROR;
                end else begin
                    state_d = RECV;
                end
            end
            DONE:    if (i_start) state_d = RECV;
            ERROR:   if (i_start) state_d = RECV;
`ifdef LOADER_CHECKSUM_EN
            CHKSUM:  if (i_rx_valid) state_d = (i_rx_data == chk_q) ? DONE : ERROR;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Write strobe is decoded from the state so reset drops it asynchronously.
    always_comb begin
        o_wr_en      = state_q == WRITE;
        o_busy       = state_q == RECV || state_q == WRITE || state_q == CHKSUM;
        o_done       = state_q == DONE;
        o_error      = state_q == ERROR;
        o_wr_addr    = wrAddr_q;
        o_wr_data    = wrData_q;
        o_word_count = wordCount_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_q      <= '0;
            wrData_q    <= '0;
            addr_q      <= '0;
            wrAddr_q    <= '0;
            wordCount_q <= '0;
            byteIdx_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else if (startSession) begin
            word_q      <= '0;
            addr_q      <= '0;
            wordCount_q <= '0;
            byteIdx_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else if (byteAccept) begin
            word_q    <= {word_q[DATA_WIDTH-9:0], i_rx_data};
            byteIdx_q <= byteIdx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            chk_q     <= chk_q ^ i_rx_data;
`endif
            if (lastByte) begin
                wrData_q <= {word_q[DATA_WIDTH-9:0], i_rx_data};
                wrAddr_q <= addr_q;
            end
        end else if (state_q == WRITE) begin
            wordCount_q <= wordCount_q + (ADDR_WIDTH+1)'(1);
            if (!isHalt && addr_q != LAST_ADDR) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table-driven word session plus
// hand-written timing, overflow, reset-abort and restart sequences.
module tb_instr_mem_loader;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_wr_en;
    logic [6:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [7:0]  o_word_count;

    int checks   = 0;
    int failures = 0;
    logic [7:0]  tbChk;
    logic [6:0]  wrAddrQ[$];
    logic [31:0] wrDataQ[$];

    typedef struct {
        logic [31:0] word;
        logic [6:0]  expAddr;
        logic        expDone;
        logic [7:0]  expCount;
    } vec_t;

    instr_mem_loader dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_word_count (o_word_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Every cycle with the write strobe high is logged as one memory write.
    always @(negedge i_clk) begin
        if (o_wr_en === 1'b1) begin
            wrAddrQ.push_back(o_wr_addr);
            wrDataQ.push_back(o_wr_data);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sendRaw(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        tbChk = tbChk ^ b;
        sendRaw(b);
    endtask

    task automatic applyWord(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) begin
            applyStimulus(w[8*k +: 8]);
        end
    endtask

    task automatic pulseStart();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        tbChk = 8'h00;
        wrAddrQ.delete();
        wrDataQ.delete();
    endtask

    task automatic finishChk();
`ifdef LOADER_CHECKSUM_EN
        sendRaw(tbChk);
`endif
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
        checkOutput({tag, "_busy"},  32'(o_busy),  32'd0);
        checkOutput({tag, "_done"},  32'(o_done),  32'd0);
        checkOutput({tag, "_error"}, 32'(o_error), 32'd0);
        checkOutput({tag, "_count"}, 32'(o_word_count), 32'd0);
        checkOutput({tag, "_addr"},  32'(o_wr_addr), 32'd0);
        checkOutput({tag, "_data"},  o_wr_data, 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int   badAddr;
        int   badData;
        int   nWr;

        vecs[0] = '{32'h8C010001, 7'd0, 1'b0, 8'd1};
        vecs[1] = '{32'h00000000, 7'd1, 1'b0, 8'd2};
        vecs[2] = '{32'hF8000000, 7'd2, 1'b0, 8'd3};
        vecs[3] = '{32'hFBFFFFFF, 7'd3, 1'b0, 8'd4};
        vecs[4] = '{32'hFC0000A5, 7'd4, 1'b1, 8'd5};

        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        tbChk      = 8'h00;
        @(negedge i_clk);
        @(negedge i_clk);
        checkIdleOutputs("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Reference program: LW r1,1(r0) then HALT.
        pulseStart();
        applyWord(32'h8C010001);
        applyWord(32'hFC000000);
`ifdef LOADER_CHECKSUM_EN
        checkOutput("chk_busy_wait", 32'(o_busy), 32'd1);
        sendRaw(8'h70);
`endif
        checkOutput("prog_nwrites", 32'(wrAddrQ.size()), 32'd2);
        if (wrAddrQ.size() == 2) begin
            checkOutput("prog_addr0", 32'(wrAddrQ[0]), 32'd0);
            checkOutput("prog_data0", wrDataQ[0], 32'h8C010001);
            checkOutput("prog_addr1", 32'(wrAddrQ[1]), 32'd1);
            checkOutput("prog_data1", wrDataQ[1], 32'hFC000000);
        end
        checkOutput("prog_done",  32'(o_done), 32'd1);
        checkOutput("prog_count", 32'(o_word_count), 32'd2);
        checkOutput("prog_busy",  32'(o_busy), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        pulseStart();
        applyWord(32'h8C010001);
        applyWord(32'hFC000000);
        sendRaw(8'h71);
        checkOutput("badchk_error", 32'(o_error), 32'd1);
        checkOutput("badchk_done",  32'(o_done), 32'd0);
`endif

        // Table session: opcode 111110 must not be mistaken for HALT.
        pulseStart();
        for (int i = 0; i < 5; i++) begin
            applyWord(vecs[i].word);
            if (vecs[i].expDone) finishChk();
            checkOutput($sformatf("vec%0d_nwrites", i), 32'(wrAddrQ.size()), 32'(i + 1));
            if (wrAddrQ.size() == i + 1) begin
                checkOutput($sformatf("vec%0d_addr", i), 32'(wrAddrQ[i]), 32'(vecs[i].expAddr));
                checkOutput($sformatf("vec%0d_data", i), wrDataQ[i], vecs[i].word);
            end
            checkOutput($sformatf("vec%0d_done", i),  32'(o_done), 32'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d_busy", i),  32'(o_busy), 32'(!vecs[i].expDone));
            checkOutput($sformatf("vec%0d_count", i), 32'(o_word_count), 32'(vecs[i].expCount));
        end

        // Strobe timing with bytes 3 and 4 on back-to-back cycles.
        pulseStart();
        applyStimulus(8'h8C);
        applyStimulus(8'h01);
        tbChk = tbChk ^ 8'h00 ^ 8'h01;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_data  = 8'h01;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        checkOutput("timing_wr_en_hi", 32'(o_wr_en), 32'd1);
        checkOutput("timing_addr",     32'(o_wr_addr), 32'd0);
        checkOutput("timing_data",     o_wr_data, 32'h8C010001);
        @(negedge i_clk);
        checkOutput("timing_wr_en_lo", 32'(o_wr_en), 32'd0);
        checkOutput("timing_nwrites",  32'(wrAddrQ.size()), 32'd1);
        applyWord(32'hFC000000);
        finishChk();
        checkOutput("timing_done", 32'(o_done), 32'd1);

        // Fill memory without HALT.
        pulseStart();
        for (int i = 0; i < 128; i++) begin
            applyWord(32'h80000000);
        end
        nWr = wrAddrQ.size();
        checkOutput("full_nwrites", 32'(nWr), 32'd128);
        badAddr = 0;
        badData = 0;
        for (int i = 0; i < nWr; i++) begin
            if (wrAddrQ[i] !== 7'(i)) badAddr++;
            if (wrDataQ[i] !== 32'h80000000) badData++;
        end
        checkOutput("full_bad_addr", 32'(badAddr), 32'd0);
        checkOutput("full_bad_data", 32'(badData), 32'd0);
        checkOutput("full_error", 32'(o_error), 32'd1);
        checkOutput("full_done",  32'(o_done), 32'd0);
        checkOutput("full_busy",  32'(o_busy), 32'd0);
        checkOutput("full_count", 32'(o_word_count), 32'd128);

        pulseStart();
        checkOutput("restart_err_busy",  32'(o_busy), 32'd1);
        checkOutput("restart_err_error", 32'(o_error), 32'd0);
        checkOutput("restart_err_count", 32'(o_word_count), 32'd0);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        #2 i_rst_n = 1'b0;
        #1 checkIdleOutputs("midreset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        pulseStart();
        applyWord(32'hFC000000);
        checkOutput("resume_nwrites", 32'(wrAddrQ.size()), 32'd1);
        if (wrAddrQ.size() == 1) begin
            checkOutput("resume_addr", 32'(wrAddrQ[0]), 32'd0);
            checkOutput("resume_data", wrDataQ[0], 32'hFC000000);
        end
        finishChk();
        checkOutput("resume_done", 32'(o_done), 32'd1);

        // Reset while the write strobe is high.
        pulseStart();
        applyStimulus(8'h8C);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        i_rx_data  = 8'h01;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        checkOutput("inflight_wr_en_hi", 32'(o_wr_en), 32'd1);
        #1 i_rst_n = 1'b0;
        #1 checkOutput("inflight_wr_en_lo", 32'(o_wr_en), 32'd0);
        checkOutput("inflight_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Bytes in IDLE and DONE must not write.
        wrAddrQ.delete();
        wrDataQ.delete();
        applyWord(32'hFC000000);
        checkOutput("idle_nwrites", 32'(wrAddrQ.size()), 32'd0);
        checkOutput("idle_busy",    32'(o_busy), 32'd0);
        pulseStart();
        applyWord(32'h8C010001);
        applyWord(32'hFC000000);
        finishChk();
        checkOutput("done2_done", 32'(o_done), 32'd1);
        applyWord(32'h11223344);
        checkOutput("done_bytes_nwrites", 32'(wrAddrQ.size()), 32'd2);
        checkOutput("done_bytes_count",   32'(o_word_count), 32'd2);
        pulseStart();
        checkOutput("restart_done_count", 32'(o_word_count), 32'd0);
        checkOutput("restart_done_busy",  32'(o_busy), 32'd1);
        applyWord(32'hFC000001);
        checkOutput("restart_done_nwrites", 32'(wrAddrQ.size()), 32'd1);
        if (wrAddrQ.size() == 1) begin
            checkOutput("restart_done_addr", 32'(wrAddrQ[0]), 32'd0);
            checkOutput("restart_done_data", wrDataQ[0], 32'hFC000001);
        end
        finishChk();
        checkOutput("restart_done_final", 32'(o_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
